// File: rtl/wb_host_master.sv
// ============================================================================
//  Module   : wb_host_master
//  Brief    : Single-command Wishbone classic-cycle initiator with valid/ready
//             request/response ports and debug counters. Define WBM_TIMEOUT_EN
//             to build the ack timeout (TIMEOUT_CYCLES) and error counting.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_host_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_adr,
    input  logic [DW-1:0]     req_dat,
    input  logic [DW/8-1:0]   req_sel,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DW-1:0]     resp_dat,
    output logic              resp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [DW-1:0]     wbm_dat_i,
    output logic [15:0]       txn_count,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_cyc;
    logic              r_we;
    logic [DW/8-1:0]   r_sel;
    logic [AW-1:0]     r_adr;
    logic [DW-1:0]     r_wdat;
    logic [DW-1:0]     r_rdat;
    logic              r_resp_valid;
    logic [15:0]       r_txn;

`ifdef WBM_TIMEOUT_EN
    logic [15:0]       r_tmo;
    logic              r_err;
    logic [7:0]        r_err_cnt;
`else
    logic              w_unused_tmo;
    assign w_unused_tmo = ^c_tmo_last;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state      <= ST_IDLE;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_wdat       <= '0;
            r_rdat       <= '0;
            r_resp_valid <= 1'b0;
            r_txn        <= 16'd0;
`ifdef WBM_TIMEOUT_EN
            r_tmo        <= 16'd0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_adr   <= req_adr;
                        r_wdat  <= req_dat;
                        r_sel   <= req_sel;
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
`ifdef WBM_TIMEOUT_EN
                        r_tmo   <= 16'd0;
`endif
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout landing on the same edge
                    if (wbm_ack_i) begin
                        r_rdat       <= r_we ? '0 : wbm_dat_i;
                        r_cyc        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_txn        <= r_txn + 16'd1;
                        r_state      <= ST_RESP;
`ifdef WBM_TIMEOUT_EN
                        r_err        <= 1'b0;
                    end else if (r_tmo == c_tmo_last) begin
                        r_rdat       <= '0;
                        r_cyc        <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_err        <= 1'b1;
                        r_txn        <= r_txn + 16'd1;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state      <= ST_RESP;
                    end else begin
                        r_tmo        <= r_tmo + 16'd1;
`endif
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE) && wb_rst_ni;
    assign resp_valid = r_resp_valid;
    assign resp_dat   = r_rdat;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_cyc;
    assign wbm_we_o   = r_we;
    assign wbm_sel_o  = r_sel;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_wdat;
    assign txn_count  = r_txn;

`ifdef WBM_TIMEOUT_EN
    assign resp_err   = r_err;
    assign err_count  = r_err_cnt;
`else
    assign resp_err   = 1'b0;
    assign err_count  = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_host_master.sv
// ============================================================================
//  Module   : tb_wb_host_master
//  Brief    : Randomized self-checking bench for wb_host_master against a
//             transaction-level reference model (honours WBM_TIMEOUT_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_host_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_adr = '0;
    logic [DW-1:0]   req_dat = '0;
    logic [SW-1:0]   req_sel = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_dat;
    logic            resp_err;
    logic            cyc, stb, we;
    logic [SW-1:0]   sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   wdat;
    logic            ack = 1'b0;
    logic [DW-1:0]   rdat_bus = '0;
    logic [15:0]     txn_count;
    logic [7:0]      err_count;

    int total = 0;
    int bad   = 0;
    int m_txn = 0;
    int m_err = 0;

    always #5 clk = ~clk;

    wb_host_master #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_adr    (req_adr),
        .req_dat    (req_dat),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dat   (resp_dat),
        .resp_err   (resp_err),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (wdat),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (rdat_bus),
        .txn_count  (txn_count),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_txn();
        return 16'(m_txn % 65536);
    endfunction

    function automatic logic [7:0] exp_err();
        return (m_err > 255) ? 8'hFF : 8'(m_err);
    endfunction

    // One full command: request, ack after 'delay' wait cycles, 'hold' cycles of response backpressure
    task automatic do_txn(input logic t_we, input logic [AW-1:0] t_adr, input logic [DW-1:0] t_dat,
                          input logic [SW-1:0] t_sel, input int delay, input logic [DW-1:0] t_rdat,
                          input int hold);
        int          n_end;
        bit          to;
        logic [DW-1:0] e_dat;
        to    = TO_EN && (delay >= TMO);
        n_end = to ? TMO - 1 : delay;
        e_dat = (to || t_we) ? '0 : t_rdat;

        check("idle_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we = t_we; req_adr = t_adr; req_dat = t_dat; req_sel = t_sel;
        ack = 1'($urandom_range(0, 1));
        rdat_bus = $urandom;
        step();

        for (int n = 0; n <= n_end; n++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom_range(0, 1)); req_adr = $urandom; req_dat = $urandom;
            check("bus_cyc", cyc, 1'b1);
            check("bus_stb", stb, 1'b1);
            check("bus_adr", adr, t_adr);
            check("bus_dat", wdat, t_dat);
            check("bus_we", we, t_we);
            check("bus_sel", sel, t_sel);
            check("bus_ready", req_ready, 1'b0);
            check("bus_rvalid", resp_valid, 1'b0);
            ack = (n == delay);
            rdat_bus = (n == delay) ? t_rdat : $urandom;
            step();
        end

        m_txn++;
        if (to) m_err++;
        check("end_cyc", cyc, 1'b0);
        check("end_stb", stb, 1'b0);
        check("resp_valid", resp_valid, 1'b1);
        check("resp_dat", resp_dat, e_dat);
        check("resp_err", resp_err, to);
        check("txn_count", txn_count, exp_txn());
        check("err_count", err_count, exp_err());

        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_adr = $urandom; req_we = 1'($urandom_range(0, 1));
            ack = 1'($urandom_range(0, 1));
            rdat_bus = $urandom;
            resp_ready = 1'b0;
            step();
            check("hold_valid", resp_valid, 1'b1);
            check("hold_dat", resp_dat, e_dat);
            check("hold_err", resp_err, to);
            check("hold_ready", req_ready, 1'b0);
            check("hold_cyc", cyc, 1'b0);
            check("hold_txn", txn_count, exp_txn());
        end

        ack = 1'($urandom_range(0, 1));
        resp_ready = 1'b1;
        step();
        check("done_valid", resp_valid, 1'b0);
        check("done_ready", req_ready, 1'b1);
        check("done_cyc", cyc, 1'b0);
        req_valid = 1'b0;
        resp_ready = 1'b0;

        // Stray ack while idle must not start anything
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("idle_ack_cyc", cyc, 1'b0);
        check("idle_ack_txn", txn_count, exp_txn());
        check("idle_ack_err", err_count, exp_err());
        check("idle_ack_valid", resp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("rst_cyc", cyc, 1'b0);
        check("rst_stb", stb, 1'b0);
        check("rst_adr", adr, '0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_txn", txn_count, 16'd0);
        check("rst_err", err_count, 8'd0);
        check("rst_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", req_ready, 1'b1);

        do_txn(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'h5555_AAAA, 0);
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'h0000_1234, 0);
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 5);
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, TMO - 1, 32'h0BAD_CAFE, 1);
        do_txn(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hC, 100, 32'h7777_8888, 2);

        for (int i = 0; i < 30; i++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 6), $urandom, $urandom_range(0, 3));
        end

        // Reset landing on the second BUS cycle
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0100; req_sel = 4'hF;
        ack = 1'b0;
        step();
        req_valid = 1'b0;
        check("mid_cyc0", cyc, 1'b1);
        step();
        check("mid_cyc1", cyc, 1'b1);
        rst_n = 1'b0;
        step();
        m_txn = 0;
        m_err = 0;
        check("mid_rst_cyc", cyc, 1'b0);
        check("mid_rst_stb", stb, 1'b0);
        check("mid_rst_valid", resp_valid, 1'b0);
        check("mid_rst_txn", txn_count, exp_txn());
        check("mid_rst_err", err_count, exp_err());
        check("mid_rst_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        ack = 1'b1;
        rdat_bus = 32'hFFFF_FFFF;
        step();
        step();
        ack = 1'b0;
        check("stray_cyc", cyc, 1'b0);
        check("stray_valid", resp_valid, 1'b0);
        check("stray_txn", txn_count, exp_txn());
        check("stray_ready", req_ready, 1'b1);

        do_txn(1'b0, 32'h3000_0200, 32'h0, 4'hF, 0, 32'h0000_00A5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
